// File: rtl/tt_ctrl_pkg.sv
// Shared definitions for the mux-select initiator: FSM state encoding,
// default timing constants and the phase-timer width helper.
package tt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIS    = 3'd1,
        ST_RST    = 3'd2,
        ST_INC_H  = 3'd3,
        ST_INC_L  = 3'd4,
        ST_SETTLE = 3'd5
    } state_e;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_MAX_ADDR   = 1023;
    localparam int DEF_RST_CYC    = 2;
    localparam int DEF_PULSE_CYC  = 1;
    localparam int DEF_SETTLE_CYC = 2;

    // The timer holds CYC-1 at most, so clog2 of the largest phase suffices (min 1 bit).
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tt_ctrl_sel_timer.sv
// Loadable down-counter that times each FSM phase; zero_o marks the last cycle
// of the phase that was loaded with (cycles - 1).
module tt_ctrl_sel_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_ctrl_sel_seq.sv
// Mux-select initiator: turns a target design address into the select-counter
// reset/increment pulse train, tracks the selected address, then drives ctrl_ena.
module tt_ctrl_sel_seq
    import tt_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MAX_ADDR   = DEF_MAX_ADDR,
    parameter int RST_CYC    = DEF_RST_CYC,
    parameter int PULSE_CYC  = DEF_PULSE_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              req_ready,
    output logic              req_err,
    output logic              busy,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_vld,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    localparam int                TMR_W = tmr_width(RST_CYC, PULSE_CYC, SETTLE_CYC);
    localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] tgt_q;
    logic              ena_q;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              cur_vld_q, cur_vld_d;
    logic              ctrl_ena_q, ctrl_ena_d;
    logic              err_q, err_d;
    logic              sel_rst_n_q, sel_rst_n_d;
    logic              sel_inc_q, sel_inc_d;
    logic              ready_q, ready_d;
    logic              tmr_load, tmr_zero;
    logic [TMR_W-1:0]  tmr_val;
    logic              accept, addr_bad, addr_hit;

    assign accept   = req_valid && ready_q;
    assign addr_bad = (req_addr > MAX_A);
    assign addr_hit = cur_vld_q && (req_addr == cur_addr_q);

    tt_ctrl_sel_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && !addr_bad && !addr_hit) state_d = ST_DIS;
            end
            ST_DIS: begin
                if (!cur_vld_q || (tgt_q < cur_addr_q)) state_d = ST_RST;
                else if (tgt_q == cur_addr_q)            state_d = ST_SETTLE;
                else                                     state_d = ST_INC_H;
            end
            ST_RST: begin
                if (tmr_zero) state_d = (tgt_q != '0) ? ST_INC_H : ST_SETTLE;
            end
            ST_INC_H: begin
                if (tmr_zero) state_d = ST_INC_L;
            end
            ST_INC_L: begin
                if (tmr_zero) state_d = (cur_addr_q != tgt_q) ? ST_INC_H : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_zero) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Each phase change reloads the timer with the new phase length minus one.
    always_comb begin
        tmr_load = (state_d != state_q);
        unique case (state_d)
            ST_RST:             tmr_val = TMR_W'(RST_CYC - 1);
            ST_INC_H, ST_INC_L: tmr_val = TMR_W'(PULSE_CYC - 1);
            ST_SETTLE:          tmr_val = TMR_W'(SETTLE_CYC - 1);
            default:            tmr_val = '0;
        endcase
    end

    always_comb begin
        cur_addr_d  = cur_addr_q;
        cur_vld_d   = cur_vld_q;
        ctrl_ena_d  = ctrl_ena_q;
        err_d       = 1'b0;
        sel_rst_n_d = (state_d != ST_RST);
        sel_inc_d   = (state_d == ST_INC_H);
        ready_d     = (state_d == ST_IDLE);
        if ((state_q == ST_IDLE) && accept) begin
            if (addr_bad)      err_d      = 1'b1;
            else if (addr_hit) ctrl_ena_d = req_ena;
        end
        if (state_q == ST_DIS) ctrl_ena_d = 1'b0;
        if (state_d == ST_RST) cur_vld_d = 1'b0;
        if ((state_q == ST_RST) && (state_d != ST_RST)) begin
            cur_vld_d  = 1'b1;
            cur_addr_d = '0;
        end
        // The counters advance on the rising inc edge, so the position moves on INC_H entry.
        if ((state_d == ST_INC_H) && (state_q != ST_INC_H)) begin
            cur_addr_d = ((state_q == ST_RST) ? '0 : cur_addr_q) + ADDR_W'(1);
        end
        if ((state_q == ST_SETTLE) && (state_d == ST_IDLE)) ctrl_ena_d = ena_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_addr_q  <= '0;
            cur_vld_q   <= 1'b0;
            ctrl_ena_q  <= 1'b0;
            err_q       <= 1'b0;
            sel_rst_n_q <= 1'b0;
            sel_inc_q   <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            cur_addr_q  <= cur_addr_d;
            cur_vld_q   <= cur_vld_d;
            ctrl_ena_q  <= ctrl_ena_d;
            err_q       <= err_d;
            sel_rst_n_q <= sel_rst_n_d;
            sel_inc_q   <= sel_inc_d;
            ready_q     <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tgt_q <= req_addr;
            ena_q <= req_ena;
        end
    end

    assign req_ready      = ready_q;
    assign busy           = ~ready_q;
    assign req_err        = err_q;
    assign cur_addr       = cur_addr_q;
    assign cur_vld        = cur_vld_q;
    assign ctrl_sel_rst_n = sel_rst_n_q;
    assign ctrl_sel_inc   = sel_inc_q;
    assign ctrl_ena       = ctrl_ena_q;

endmodule
